// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
// Sequences the external raster position counter (increment strobe), starts
// and stops scanning only on frame boundaries, and decodes hcount/vcount into
// registered hsync/vsync/de. Pixels are pulled from a valid/ready stream in
// the active region; a fixed colour is substituted when the source underflows.
//
// Ports:
//   clk, rstn        pixel clock, async active-low reset
//   i_enable         level request to scan frames
//   o_inc            increment strobe to the raster counter
//   i_hcount/vcount  raster counter position
//   i_pix_valid/data upstream pixel stream, o_pix_ready = accepted this cycle
//   o_hsync/o_vsync  registered syncs (polarity per *_POL)
//   o_de, o_pix_data registered data enable and aligned pixel
//   o_frame_start    one-cycle pulse for position (0,0)
//   o_underflow      sticky underflow flag, cleared by i_underflow_clr
module video_timing_ctrl #(
  parameter int HACTIVE = 640,
  parameter int HFP = 16,
  parameter int HSYNC = 96,
  parameter int HBP = 48,
  parameter int VACTIVE = 480,
  parameter int VFP = 10,
  parameter int VSYNC = 2,
  parameter int VBP = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_W = 24,
  parameter logic [PIX_W-1:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int HMAX = HACTIVE + HFP + HSYNC + HBP,
  localparam int VMAX = VACTIVE + VFP + VSYNC + VBP,
  localparam int HLEN = $clog2(HMAX),
  localparam int VLEN = $clog2(VMAX)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_enable,
  output logic             o_inc,
  input  logic [HLEN-1:0]  i_hcount,
  input  logic [VLEN-1:0]  i_vcount,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_pix_ready,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_frame_start,
  output logic             o_underflow,
  input  logic             i_underflow_clr
);

  // Boundaries truncated to the counter widths so all compares are unsigned
  // at HLEN/VLEN bits.
  localparam logic [HLEN-1:0] H_ACT  = HLEN'(HACTIVE);
  localparam logic [HLEN-1:0] H_SS   = HLEN'(HACTIVE + HFP);
  localparam logic [HLEN-1:0] H_SE   = HLEN'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [HLEN-1:0] H_LAST = HLEN'(HMAX - 1);
  localparam logic [VLEN-1:0] V_ACT  = VLEN'(VACTIVE);
  localparam logic [VLEN-1:0] V_SS   = VLEN'(VACTIVE + VFP);
  localparam logic [VLEN-1:0] V_SE   = VLEN'(VACTIVE + VFP + VSYNC - 1);
  localparam logic [VLEN-1:0] V_LAST = VLEN'(VMAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
  state_t state;

  logic run, active, hs, vs, last_pos, xfer;

  // Decode is gated by run so IDLE forces sync inactive, de and ready low.
  assign run      = (state != IDLE);
  assign active   = run && (i_hcount < H_ACT) && (i_vcount < V_ACT);
  assign hs       = run && (i_hcount >= H_SS) && (i_hcount <= H_SE);
  assign vs       = run && (i_vcount >= V_SS) && (i_vcount <= V_SE);
  assign last_pos = (i_hcount == H_LAST) && (i_vcount == V_LAST);
  assign xfer     = active && i_pix_valid;

  assign o_pix_ready = active;

  // o_inc is registered alongside the state so it always equals state != IDLE.
  // Leaving STOP_PEND at the last position keeps o_inc high for that cycle,
  // which lets the counter wrap to (0,0) before it is frozen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      o_inc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_enable) begin
          state <= RUN;
          o_inc <= 1'b1;
        end
        RUN: if (!i_enable) state <= STOP_PEND;
        STOP_PEND: begin
          if (i_enable) state <= RUN;
          else if (last_pos) begin
            state <= IDLE;
            o_inc <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          o_inc <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_de          <= 1'b0;
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
      o_pix_data    <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      o_de    <= active;
      o_hsync <= hs ^ ~HSYNC_POL;
      o_vsync <= vs ^ ~VSYNC_POL;
      if (xfer)        o_pix_data <= i_pix_data;
      else if (active) o_pix_data <= UNDERFLOW_COLOR;
      else             o_pix_data <= '0;
      o_frame_start <= run && (i_hcount == '0) && (i_vcount == '0);
      // A new underflow outranks a simultaneous clear.
      if (active && !i_pix_valid) o_underflow <= 1'b1;
      else if (i_underflow_clr)   o_underflow <= 1'b0;
    end
  end

endmodule
